// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the MIPS HI/LO multiply/divide unit.
package mdu_pkg;

   localparam int unsigned MDU_XLEN  = 32;
   localparam int unsigned MDU_ITERS = MDU_XLEN;

   localparam logic [MDU_XLEN-1:0] MDU_DIV0_QUOT = '1;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = MDU_ITERS
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            is_div_i,
   input  logic [XLEN-1:0] load_lo_i,
   input  logic [XLEN-1:0] operand_i,
   output logic            last_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned AW = 2 * XLEN;

   logic [AW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] opnd_q;
   logic            div_q;
   logic [CW-1:0]   cnt_q;
   logic            last_q;

   logic [XLEN:0]   sum_c;
   logic [XLEN:0]   shr_c;
   logic [XLEN:0]   diff_c;

   // Mul: accumulator = {partial product, remaining multiplier bits}.
   // Div: accumulator = {partial remainder, dividend/quotient bits}.
   always_comb begin
      sum_c  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      shr_c  = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
      diff_c = shr_c - {1'b0, opnd_q};
      acc_d  = {sum_c, acc_q[XLEN-1:1]};
      if (div_q) begin
         if (diff_c[XLEN]) acc_d = {shr_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         else              acc_d = {diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else if (load_i) begin
         acc_q  <= {XLEN'(0), load_lo_i};
         opnd_q <= operand_i;
         div_q  <= is_div_i;
         cnt_q  <= CW'(XLEN - 1);
         last_q <= 1'b0;
      end else if (step_i) begin
         acc_q  <= acc_d;
         if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
         last_q <= (cnt_q == CW'(1));
      end
   end

   assign last_o = last_q;
   assign hi_o   = acc_q[AW-1:XLEN];
   assign lo_o   = acc_q[XLEN-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO unit: FSM, sign handling, special cases and HI/LO registers.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = MDU_XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned PW = 2 * XLEN;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e      state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic            is_div_q, neg_q, rem_neg_q, dz_q, ovf_q;
   logic [XLEN-1:0] dvd_q;

   mdu_op_e         op_c;
   logic            accept_c, is_div_c, signed_c, a_neg_c, b_neg_c;
   logic            iter_start_c, step_c;
   logic [XLEN-1:0] a_mag_c, b_mag_c;
   logic            core_last;
   logic [XLEN-1:0] core_hi, core_lo;
   logic [PW-1:0]   prod_fix_c;
   logic [XLEN-1:0] quot_fix_c, rem_fix_c;

   assign op_c     = mdu_op_e'(op);
   assign accept_c = start && (state_q == ST_IDLE) && (op <= 3'(OP_MTLO));
   assign is_div_c = (op_c == OP_DIV) || (op_c == OP_DIVU);
   assign signed_c = (op_c == OP_MULT) || (op_c == OP_DIV);
   assign a_neg_c  = signed_c && srcA[XLEN-1];
   assign b_neg_c  = signed_c && srcB[XLEN-1];
   assign a_mag_c  = a_neg_c ? -srcA : srcA;
   assign b_mag_c  = b_neg_c ? -srcB : srcB;

`ifdef MDU_FAST_MUL_EN
   logic            fast_mul_c;
   logic [PW-1:0]   fast_prod_c;
   assign fast_mul_c   = accept_c && ((op_c == OP_MULT) || (op_c == OP_MULTU));
   // Sign-extended operands give the signed product modulo 2^PW.
   assign fast_prod_c  = PW'({{XLEN{a_neg_c}}, srcA} * {{XLEN{b_neg_c}}, srcB});
   assign iter_start_c = accept_c && is_div_c;
`else
   assign iter_start_c = accept_c && (op <= 3'(OP_DIVU));
`endif

   mdu_iter_core #(.XLEN(XLEN)) u_core (
      .clk_i     (clock),
      .rst_ni    (reset),
      .load_i    (iter_start_c),
      .step_i    (step_c),
      .is_div_i  (is_div_c),
      .load_lo_i (is_div_c ? a_mag_c : b_mag_c),
      .operand_i (is_div_c ? b_mag_c : a_mag_c),
      .last_o    (core_last),
      .hi_o      (core_hi),
      .lo_o      (core_lo)
   );

   assign prod_fix_c = neg_q     ? -{core_hi, core_lo} : {core_hi, core_lo};
   assign quot_fix_c = neg_q     ? -core_lo            : core_lo;
   assign rem_fix_c  = rem_neg_q ? -core_hi            : core_hi;

   // Next state and HI/LO update.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      step_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iter_start_c) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end
            if (accept_c && (op_c == OP_MTHI)) hi_d = srcA;
            if (accept_c && (op_c == OP_MTLO)) lo_d = srcA;
`ifdef MDU_FAST_MUL_EN
            if (fast_mul_c) begin
               {hi_d, lo_d} = fast_prod_c;
               done_d       = 1'b1;
            end
`endif
         end
         ST_RUN: begin
            step_c = 1'b1;
            if (core_last) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix_c;
            end else if (dz_q) begin
               lo_d = XLEN'(MDU_DIV0_QUOT);
               hi_d = dvd_q;
            end else if (ovf_q) begin
               lo_d = INT_MIN;
               hi_d = '0;
            end else begin
               lo_d = quot_fix_c;
               hi_d = rem_fix_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Result signs and special cases are frozen at acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         dvd_q     <= '0;
      end else if (iter_start_c) begin
         is_div_q  <= is_div_c;
         neg_q     <= a_neg_c ^ b_neg_c;
         rem_neg_q <= a_neg_c;
         dz_q      <= is_div_c && (srcB == '0);
         ovf_q     <= (op_c == OP_DIV) && (srcA == INT_MIN) && (srcB == '1);
         dvd_q     <= srcA;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
